booth_mul_sched: RTL and testbench
==================================

Name: booth_mul_sched

Overview:
- Sequential radix-2 Booth multiply engine shared by two requesters.
- A round-robin arbiter grants one request at a time into a single-step-per-cycle Booth datapath.
- The tagged signed product is returned over a valid/ready result port.
- Sits between the two operand producers and the downstream accumulate/writeback stage. It is the area-saving alternative to the fully unrolled combinational multiplier.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 multiplicand (two's complement)
- req0_b  in  WIDTH  requester 0 multiplier (two's complement)
- req1_valid / req1_ready / req1_a / req1_b  same as requester 0, for requester 1
- res_valid  out  1  product available
- res_ready  in  1  consumer takes product
- res_p  out  2*WIDTH  signed product A*B
- res_id  out  1  requester index that issued the product
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (synchronous, on any edge with rst=1, including mid-operation):
  - state=IDLE, res_valid=0, res_p=0, res_id=0, busy=0.
  - Round-robin pointer = requester 0. Accumulator, Q, Q_1 and counter = 0.
  - Any in-flight operation is discarded; no result is produced for it.
- States:
  - IDLE: arbitrate between requesters.
  - RUN: one Booth step per cycle.
  - DONE: hold the result until it is accepted.
- Arbitration (IDLE only):
  - reqN_ready is combinational: 1 only for the granted requester, only in IDLE.
  - Grant rule:
    - Only one valid: grant it.
    - Both valid: grant the pointer's requester.
    - Neither valid: no grant.
  - On the accept edge:
    - Latch A and B; Q=B, Q_1=0, accumulator=0, counter=WIDTH.
    - Record res_id = granted index; pointer = other index; go to RUN.
  - Ready is never asserted in RUN or DONE.
- Booth step (each RUN edge):
  - (Q[0],Q_1)=10: acc = acc - A.
  - (Q[0],Q_1)=01: acc = acc + A.
  - 00 / 11: no add.
  - Then arithmetic right shift of {acc,Q,Q_1} by one bit; counter decrements.
  - Accumulator is WIDTH+1 bits, with A sign-extended to WIDTH+1 bits. This makes A = -2^(WIDTH-1) correct.
  - After the step that takes the counter to 0: res_p = low 2*WIDTH bits of {acc,Q}, res_valid=1, go to DONE.
- Latency:
  - Accept on edge k; WIDTH RUN edges k+1..k+WIDTH.
  - res_valid=1 after edge k+WIDTH (32 cycles at default).
  - Operand changes on reqN_* after accept have no effect.
- DONE:
  - res_valid, res_p and res_id are held stable while res_ready=0.
  - On an edge with res_ready=1: res_valid=0, go to IDLE.
  - The next accept happens no earlier than the following edge (one bubble cycle minimum between results).
- Simultaneous events:
  - Both requesters valid in IDLE: only the pointer's requester sees ready.
  - A requester that holds valid continuously alternates service with the other.
  - rst takes priority over every handshake in the same cycle.

Test Plan:
- Single request: req0 a=7, b=-3; res_ready=1 held -> req0_ready pulses one cycle; res_valid rises exactly 32 cycles after accept; res_p=64'hFFFF_FFFF_FFFF_FFEB, res_id=0; busy high from accept until the result handshake.
- Boundary operands: a=32'h8000_0000, b=32'h8000_0000 -> res_p=64'h4000_0000_0000_0000. Also a=32'h8000_0000, b=1 -> res_p=64'hFFFF_FFFF_8000_0000. Also a=0, b=-1 -> 0.
- Contention: req0 and req1 both valid continuously after reset, with different operands -> service order 0,1,0,1; each res_p matches its requester; res_id alternates.
- Backpressure: res_ready=0 for 10 cycles after res_valid rises -> res_p and res_id stable, no reqN_ready asserted; res_ready=1 -> next accept no sooner than one cycle after the handshake edge.
- Reset mid-run: assert rst for one cycle 15 cycles after accepting a=5, b=5 -> res_valid stays 0, busy=0, pointer back to 0. A subsequent request a=5, b=5 returns 25 after 32 cycles.
- Random regression: 1000 random signed pairs alternating requesters with random res_ready -> every res_p equals the 64-bit signed A*B, and the ordering matches the arbitration rule.

Source files
------------

// File: rtl/booth_mul_sched.sv
// Radix-2 Booth multiplier shared by two requesters through a round-robin arbiter.
// One Booth step per cycle. The tagged signed product leaves on a valid/ready port.
module booth_mul_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_p,
    output logic                 res_id,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic                 r_ptr;
    logic [WIDTH:0]       r_a;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q1;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_res_p;
    logic                 r_res_valid;
    logic                 r_res_id;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_acc_nxt;
    logic [WIDTH-1:0]     w_q_nxt;

    // A lone requester always wins; on contention the pointer decides.
    assign w_gnt0 = (r_state == S_IDLE) && req0_valid && (!req1_valid || !r_ptr);
    assign w_gnt1 = (r_state == S_IDLE) && req1_valid && (!req0_valid ||  r_ptr);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b10:   w_sum = r_acc - r_a;
            2'b01:   w_sum = r_acc + r_a;
            default: w_sum = r_acc;
        endcase
    end

    // The accumulator is one bit wider than A, so A = -2^(WIDTH-1) is negated without overflow.
    assign w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};

    // NOTE: state is updated with non-blocking assignments only, so each edge sees the values from the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_a         <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_q1        <= 1'b0;
            r_cnt       <= '0;
            r_res_p     <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a      <= w_gnt1 ? {req1_a[WIDTH-1], req1_a} : {req0_a[WIDTH-1], req0_a};
                        r_q      <= w_gnt1 ? req1_b : req0_b;
                        r_q1     <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_res_id <= w_gnt1;
                        r_ptr    <= ~w_gnt1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_res_p     <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_p     = r_res_p;
    assign res_id    = r_res_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched. Directed and random stimulus are checked against
// a reference model that uses plain signed multiplication and a round-robin grant pointer.
module tb_booth_mul_sched;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic               res_valid, res_ready;
    logic [2*WIDTH-1:0] res_p;
    logic               res_id;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    bit ptr_model = 1'b0;

    booth_mul_sched #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Present one request, wait (bounded) for its grant, then withdraw and scramble the operands.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        while (!(id == 0 ? req0_ready : req1_ready) && waited < 100) begin
            @(negedge clk); #1; waited++;
        end
        check("grant_wait", 64'(waited < 100), 64'd1);
        @(negedge clk);
        ptr_model = (id == 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    endtask

    // Called at the negedge right after the accept edge; waits for the result and handshakes it.
    task automatic collect(input int exp_id, input logic [63:0] exp_p, input bit detail, input int stall);
        int cyc = 0;
        logic [63:0] held_p;
        logic        held_id;
        while (!res_valid && cyc < 200) begin
            if (detail) begin
                check("busy_run", busy, 1);
                check("ready_in_run", {req0_ready, req1_ready}, 0);
            end
            @(negedge clk);
            cyc++;
        end
        check("result_wait", 64'(cyc < 200), 64'd1);
        if (detail) check("latency", cyc, WIDTH);
        check("res_p", res_p, exp_p);
        check("res_id", res_id, exp_id);
        held_p = res_p;
        held_id = res_id;
        if (stall > 0) begin
            res_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("hold_valid", res_valid, 1);
                check("hold_p", res_p, held_p);
                check("hold_id", res_id, held_id);
                check("hold_no_ready", {req0_ready, req1_ready}, 0);
            end
            res_ready = 1'b1;
        end
        @(negedge clk);
        check("post_hs_valid", res_valid, 0);
        check("post_hs_busy", busy, 0);
    endtask

    initial begin
        logic [31:0] a0, b0, a1, b1, ra, rb;
        int          mask, exp_id;
        bit          seen;

        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res_p", res_p, 0);
        check("rst_res_id", res_id, 0);
        rst = 1'b0;
        ptr_model = 1'b0;

        // Both requesters valid continuously: service must alternate starting at 0.
        a0 = 32'd1234; b0 = 32'hFFFF_FF00; a1 = 32'h8000_0001; b1 = 32'd77;
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = int'(ptr_model);
            #1;
            check("cont_ready0", req0_ready, 64'(exp_id == 0));
            check("cont_ready1", req1_ready, 64'(exp_id == 1));
            @(negedge clk);
            ptr_model = (exp_id == 0);
            collect(exp_id, exp_id == 0 ? ref_mul(a0, b0) : ref_mul(a1, b1), 1'b1, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        // Single request and operand boundaries.
        issue(0, 32'd7, 32'hFFFF_FFFD);
        collect(0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 0);
        issue(1, 32'h8000_0000, 32'h8000_0000);
        collect(1, 64'h4000_0000_0000_0000, 1'b1, 0);
        issue(0, 32'h8000_0000, 32'd1);
        collect(0, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);
        issue(1, 32'd0, 32'hFFFF_FFFF);
        collect(1, 64'd0, 1'b1, 0);

        // Backpressure with requester 1 waiting; it may only be granted after the handshake.
        issue(0, 32'd100, 32'hFFFF_FFF6);
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd11;
        collect(0, 64'hFFFF_FFFF_FFFF_FC18, 1'b1, 10);
        #1;
        check("bp_next_grant", req1_ready, 1);
        issue(1, 32'd9, 32'd11);
        collect(1, 64'd99, 1'b1, 0);

        // Reset in the middle of an operation discards it and rewinds the pointer.
        issue(0, 32'd5, 32'd5);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr_model = 1'b0;
        check("midrst_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("midrst_no_result", seen, 0);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3;
        #1;
        check("midrst_ptr0", req0_ready, 1);
        check("midrst_ptr1", req1_ready, 0);
        req1_valid = 1'b0;
        issue(0, 32'd5, 32'd5);
        collect(0, 64'd25, 1'b1, 0);

        // Random regression: random requester mix, operands and result backpressure.
        for (int n = 0; n < 1000; n++) begin
            mask = $urandom_range(1, 3);
            a0 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b0 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            a1 = $urandom;
            b1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            req0_valid = mask[0]; req0_a = a0; req0_b = b0;
            req1_valid = mask[1]; req1_a = a1; req1_b = b1;
            exp_id = (mask == 3) ? int'(ptr_model) : (mask == 2 ? 1 : 0);
            ra = (exp_id == 0) ? a0 : a1;
            rb = (exp_id == 0) ? b0 : b1;
            #1;
            check("rnd_ready0", req0_ready, 64'(exp_id == 0));
            check("rnd_ready1", req1_ready, 64'(exp_id == 1));
            @(negedge clk);
            ptr_model = (exp_id == 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            collect(exp_id, ref_mul(ra, rb), 1'b0, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
